// File: rtl/dzcpu_useq.sv
// dzcpu_useq: RAM-backed microcode sequencer with loadable primary and 0xCB dispatch tables.
// Optional macro DZCPU_USEQ_ILLEGAL_TRAP_EN: a zero dispatch entry traps and latches the opcode.
module dzcpu_useq #(
    parameter int         UOP_W    = 13,
    parameter int         ADDR_W   = 8,
    parameter logic [7:0] IRQ_FLOW = 8'd238
) (
    input  logic              iClock,
    input  logic              iReset_n,
    input  logic              iStart,
    input  logic [7:0]        iOp,
    input  logic              iOpValid,
    output logic              oOpReady,
    input  logic              iStall,
    input  logic              iFlagZ,
    input  logic              iIrqReq,
    input  logic              iIme,
    output logic              oIrqAck,
    output logic [UOP_W-1:0]  oUop,
    output logic              oUopValid,
    output logic [ADDR_W-1:0] oUpc,
    output logic              oPcInc,
    output logic              oBusy,
    input  logic              iCfgWe,
    input  logic [1:0]        iCfgSel,
    input  logic [ADDR_W-1:0] iCfgAddr,
    input  logic [UOP_W-1:0]  iCfgData
`ifdef DZCPU_USEQ_ILLEGAL_TRAP_EN
    ,
    output logic              oIllegal,
    output logic [7:0]        oIllegalOp,
    output logic              oIllegalCb
`endif
);

    typedef enum logic [2:0] {IDLE, DISPATCH, RUN, CB_WAIT, TRAP} state_t;
    typedef enum logic [2:0] {
        F_NEXT, F_INC, F_EOF, F_INC_EOF, F_INC_EOF_Z, F_INC_EOF_NZ, F_JCB, F_RSVD
    } flow_t;

    localparam logic [ADDR_W-1:0] IRQ_ADDR = ADDR_W'(IRQ_FLOW);

    state_t            state, next_state;
    logic [ADDR_W-1:0] upc, next_upc;
    logic [UOP_W-1:0]  ucode [2**ADDR_W];
    logic [ADDR_W-1:0] ptab  [256];
    logic [ADDR_W-1:0] ctab  [256];
    logic              irq_ack;
    logic              irq_take;
    logic [ADDR_W-1:0] lookup;
    flow_t             flow;

    // Writes only land while idle so a running flow never sees its own storage change.
    always_ff @(posedge iClock) begin
        if (iCfgWe && state == IDLE) begin
            case (iCfgSel)
                2'd0:    ucode[iCfgAddr]     <= iCfgData;
                2'd1:    ptab[iCfgAddr[7:0]] <= iCfgData[ADDR_W-1:0];
                2'd2:    ctab[iCfgAddr[7:0]] <= iCfgData[ADDR_W-1:0];
                default: ;
            endcase
        end
    end

    assign oUop     = ucode[upc];
    assign oUpc     = upc;
    assign oIrqAck  = irq_ack;
    assign flow     = flow_t'(oUop[UOP_W-1 -: 3]);
    assign irq_take = iIrqReq && iIme;
    assign lookup   = (state == CB_WAIT) ? ctab[iOp] : ptab[iOp];

    always_ff @(posedge iClock) begin
        if (!iReset_n) begin
            state   <= IDLE;
            upc     <= '0;
            irq_ack <= 1'b0;
        end else begin
            state   <= next_state;
            upc     <= next_upc;
            irq_ack <= (state == DISPATCH) && irq_take;
        end
    end

    always_comb begin
        next_state = state;
        next_upc   = upc;
        case (state)
            IDLE: if (iStart) next_state = DISPATCH;
            DISPATCH, CB_WAIT: begin
                // Interrupts only enter at an instruction boundary, never between CB and its suffix.
                if (state == DISPATCH && irq_take) begin
                    next_upc   = IRQ_ADDR;
                    next_state = RUN;
                end else if (iOpValid) begin
                    next_upc   = lookup;
                    next_state = RUN;
`ifdef DZCPU_USEQ_ILLEGAL_TRAP_EN
                    if (lookup == '0) next_state = TRAP;
`endif
                end
            end
            RUN: begin
                if (!iStall) begin
                    case (flow)
                        F_NEXT, F_INC: next_upc = upc + ADDR_W'(1);
                        F_INC_EOF_Z: begin
                            if (iFlagZ) next_state = DISPATCH;
                            else        next_upc   = upc + ADDR_W'(1);
                        end
                        F_INC_EOF_NZ: begin
                            if (!iFlagZ) next_state = DISPATCH;
                            else         next_upc   = upc + ADDR_W'(1);
                        end
                        F_JCB:   next_state = CB_WAIT;
                        default: next_state = DISPATCH;
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        oUopValid = (state == RUN);
        oOpReady  = (state == DISPATCH && !irq_take) || (state == CB_WAIT);
        oBusy     = (state != IDLE);
        oPcInc    = 1'b0;
        if (state == RUN && !iStall) begin
            case (flow)
                F_INC, F_INC_EOF, F_INC_EOF_Z, F_INC_EOF_NZ, F_JCB: oPcInc = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef DZCPU_USEQ_ILLEGAL_TRAP_EN
    always_ff @(posedge iClock) begin
        if (!iReset_n) begin
            oIllegal   <= 1'b0;
            oIllegalOp <= 8'h00;
            oIllegalCb <= 1'b0;
        end else if ((state == DISPATCH || state == CB_WAIT) && next_state == TRAP) begin
            oIllegal   <= 1'b1;
            oIllegalOp <= iOp;
            oIllegalCb <= (state == CB_WAIT);
        end
    end
`endif

endmodule

// File: tb/tb_dzcpu_useq.sv
// tb_dzcpu_useq: directed stimulus with a queue-based scoreboard checked by an independent monitor.
module tb_dzcpu_useq;

    localparam logic [2:0] F_NEXT = 3'd0, F_INC = 3'd1, F_EOF = 3'd2, F_INC_EOF = 3'd3;
    localparam logic [2:0] F_INC_EOF_Z = 3'd4, F_JCB = 3'd6;

    logic        iClock = 1'b0;
    logic        iReset_n = 1'b0;
    logic        iStart = 1'b0;
    logic [7:0]  iOp = 8'h00;
    logic        iOpValid = 1'b0;
    logic        oOpReady;
    logic        iStall = 1'b0;
    logic        iFlagZ = 1'b0;
    logic        iIrqReq = 1'b0;
    logic        iIme = 1'b0;
    logic        oIrqAck;
    logic [12:0] oUop;
    logic        oUopValid;
    logic [7:0]  oUpc;
    logic        oPcInc;
    logic        oBusy;
    logic        iCfgWe = 1'b0;
    logic [1:0]  iCfgSel = 2'd0;
    logic [7:0]  iCfgAddr = 8'h00;
    logic [12:0] iCfgData = 13'h0;

    typedef struct {
        logic [7:0]  upc;
        logic [12:0] uop;
        logic        pcinc;
        logic        ack;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    dzcpu_useq dut (
        .iClock(iClock), .iReset_n(iReset_n), .iStart(iStart), .iOp(iOp),
        .iOpValid(iOpValid), .oOpReady(oOpReady), .iStall(iStall), .iFlagZ(iFlagZ),
        .iIrqReq(iIrqReq), .iIme(iIme), .oIrqAck(oIrqAck), .oUop(oUop),
        .oUopValid(oUopValid), .oUpc(oUpc), .oPcInc(oPcInc), .oBusy(oBusy),
        .iCfgWe(iCfgWe), .iCfgSel(iCfgSel), .iCfgAddr(iCfgAddr), .iCfgData(iCfgData)
    );

    always #5 iClock = ~iClock;

    function automatic logic [12:0] mk(input logic [2:0] f, input logic [7:0] id);
        return {f, 2'b00, id};
    endfunction

    // Monitor: every valid uop cycle must match the next expectation queued by the stimulus.
    always @(negedge iClock) begin
        if (oUopValid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_uop: got upc=%0d uop=%h, want no valid uop", oUpc, oUop);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (oUpc !== e.upc || oUop !== e.uop || oPcInc !== e.pcinc || oIrqAck !== e.ack) begin
                    miscompares++;
                    $display("[TB] FAIL uop_stream: got upc=%0d uop=%h pcinc=%b ack=%b, want upc=%0d uop=%h pcinc=%b ack=%b",
                             oUpc, oUop, oPcInc, oIrqAck, e.upc, e.uop, e.pcinc, e.ack);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge iClock);
            #1;
        end
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    task automatic push_uop(input logic [7:0] upc, input logic [2:0] f, input logic pcinc, input logic ack);
        exp_t e;
        e.upc   = upc;
        e.uop   = mk(f, upc);
        e.pcinc = pcinc;
        e.ack   = ack;
        exp_q.push_back(e);
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [7:0] addr, input logic [12:0] data);
        iCfgWe   = 1'b1;
        iCfgSel  = sel;
        iCfgAddr = addr;
        iCfgData = data;
        tick();
        iCfgWe = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [7:0] op);
        iOp      = op;
        iOpValid = 1'b1;
        tick();
        iOpValid = 1'b0;
    endtask

    task automatic start_seq();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        @(negedge iClock);
        check_output({tag, "_busy"},  32'(oBusy), 0);
        check_output({tag, "_valid"}, 32'(oUopValid), 0);
        check_output({tag, "_ready"}, 32'(oOpReady), 0);
        check_output({tag, "_ack"},   32'(oIrqAck), 0);
        check_output({tag, "_pcinc"}, 32'(oPcInc), 0);
        check_output({tag, "_upc"},   32'(oUpc), 0);
    endtask

    initial begin
        tick(2);
        check_idle_outputs("reset");
        iReset_n = 1'b1;
        tick();

        cfg_write(2'd0, 8'd5,   mk(F_NEXT, 8'd5));
        cfg_write(2'd0, 8'd6,   mk(F_INC, 8'd6));
        cfg_write(2'd0, 8'd7,   mk(F_INC_EOF, 8'd7));
        cfg_write(2'd0, 8'd19,  mk(F_INC_EOF_Z, 8'd19));
        cfg_write(2'd0, 8'd20,  mk(F_EOF, 8'd20));
        cfg_write(2'd0, 8'd13,  mk(F_JCB, 8'd13));
        cfg_write(2'd0, 8'd16,  mk(F_EOF, 8'd16));
        cfg_write(2'd0, 8'd238, mk(F_INC_EOF, 8'd238));
        cfg_write(2'd0, 8'd255, mk(F_NEXT, 8'd255));
        cfg_write(2'd0, 8'd0,   mk(F_EOF, 8'd0));
        cfg_write(2'd1, 8'h21,  13'd5);
        cfg_write(2'd1, 8'h30,  13'd19);
        cfg_write(2'd1, 8'hCB,  13'd13);
        cfg_write(2'd1, 8'h40,  13'd255);
        cfg_write(2'd2, 8'h7C,  13'd16);

        start_seq();
        @(negedge iClock);
        check_output("start_ready", 32'(oOpReady), 1);
        check_output("start_busy",  32'(oBusy), 1);

        // Basic three-uop flow
        push_uop(8'd5, F_NEXT, 1'b0, 1'b0);
        push_uop(8'd6, F_INC, 1'b1, 1'b0);
        push_uop(8'd7, F_INC_EOF, 1'b1, 1'b0);
        apply_stimulus(8'h21);
        tick(3);
        @(negedge iClock);
        check_output("flow_end_ready", 32'(oOpReady), 1);

        // Stall three cycles on uPC 6
        push_uop(8'd5, F_NEXT, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) push_uop(8'd6, F_INC, 1'b0, 1'b0);
        push_uop(8'd6, F_INC, 1'b1, 1'b0);
        push_uop(8'd7, F_INC_EOF, 1'b1, 1'b0);
        apply_stimulus(8'h21);
        tick();
        iStall = 1'b1;
        tick(3);
        iStall = 1'b0;
        tick(2);
        @(negedge iClock);
        check_output("stall_end_ready", 32'(oOpReady), 1);

        // Conditional end on Z
        iFlagZ = 1'b1;
        push_uop(8'd19, F_INC_EOF_Z, 1'b1, 1'b0);
        apply_stimulus(8'h30);
        tick();
        @(negedge iClock);
        check_output("z1_ready", 32'(oOpReady), 1);
        iFlagZ = 1'b0;
        push_uop(8'd19, F_INC_EOF_Z, 1'b1, 1'b0);
        push_uop(8'd20, F_EOF, 1'b0, 1'b0);
        apply_stimulus(8'h30);
        tick(2);
        @(negedge iClock);
        check_output("z0_ready", 32'(oOpReady), 1);

        // CB prefix with an interrupt pending during CB_WAIT
        push_uop(8'd13, F_JCB, 1'b1, 1'b0);
        apply_stimulus(8'hCB);
        tick();
        iIrqReq = 1'b1;
        iIme    = 1'b1;
        @(negedge iClock);
        check_output("cbwait_ready", 32'(oOpReady), 1);
        check_output("cbwait_valid", 32'(oUopValid), 0);
        push_uop(8'd16, F_EOF, 1'b0, 1'b0);
        apply_stimulus(8'h7C);

        // Interrupt beats a simultaneous opcode in DISPATCH
        iOp      = 8'h21;
        iOpValid = 1'b1;
        push_uop(8'd238, F_INC_EOF, 1'b1, 1'b1);
        tick();
        @(negedge iClock);
        check_output("irq_dispatch_ready", 32'(oOpReady), 0);
        tick();
        iIrqReq  = 1'b0;
        iOpValid = 1'b0;
        tick();
        @(negedge iClock);
        check_output("irq_done_ready", 32'(oOpReady), 1);
        check_output("irq_done_ack",   32'(oIrqAck), 0);

        // IME low: interrupt ignored, opcode dispatched
        iIrqReq = 1'b1;
        iIme    = 1'b0;
        push_uop(8'd5, F_NEXT, 1'b0, 1'b0);
        push_uop(8'd6, F_INC, 1'b1, 1'b0);
        push_uop(8'd7, F_INC_EOF, 1'b1, 1'b0);
        apply_stimulus(8'h21);
        tick(3);
        @(negedge iClock);
        check_output("ime0_ready", 32'(oOpReady), 1);
        iIrqReq = 1'b0;

        // uPC wraps from 255 to 0
        push_uop(8'd255, F_NEXT, 1'b0, 1'b0);
        push_uop(8'd0, F_EOF, 1'b0, 1'b0);
        apply_stimulus(8'h40);
        tick(2);
        @(negedge iClock);
        check_output("wrap_ready", 32'(oOpReady), 1);

        // Config write in RUN is ignored; reset mid-flow
        push_uop(8'd5, F_NEXT, 1'b0, 1'b0);
        push_uop(8'd5, F_NEXT, 1'b0, 1'b0);
        apply_stimulus(8'h21);
        iStall   = 1'b1;
        iCfgWe   = 1'b1;
        iCfgSel  = 2'd0;
        iCfgAddr = 8'd6;
        iCfgData = mk(F_EOF, 8'hFF);
        tick();
        iCfgWe   = 1'b0;
        iReset_n = 1'b0;
        tick();
        check_idle_outputs("midreset");
        iReset_n = 1'b1;
        iStall   = 1'b0;
        tick();
        start_seq();
        push_uop(8'd5, F_NEXT, 1'b0, 1'b0);
        push_uop(8'd6, F_INC, 1'b1, 1'b0);
        push_uop(8'd7, F_INC_EOF, 1'b1, 1'b0);
        apply_stimulus(8'h21);
        tick(3);
        @(negedge iClock);
        check_output("restart_ready", 32'(oOpReady), 1);

        tick(2);
        check_output("queue_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dzcpu_useq.md
Name: dzcpu_useq

Overview:
- Parametrised, RAM-backed microcode sequencer for the dzcpu core; successor to the fixed opcode-to-flow LUT and uop ROM.
- Holds the micro-PC and dispatches primary and 0xCB-prefixed opcodes through two loadable dispatch tables.
- Issues one uop per cycle with stall handshake, evaluates conditional end-of-flow on Z, and injects an interrupt flow at instruction boundaries.
- Sits between the opcode fetch path and the dzcpu datapath.

Parameters:
UOP_W, 13, uop word width; flow field = oUop[UOP_W-1:UOP_W-3]
ADDR_W, 8, micro-PC width; ucode depth = 2**ADDR_W
IRQ_FLOW, 8'd238, micro-address of interrupt-entry flow (truncated to ADDR_W)

Ports:
iClock  in  1  clock
iReset_n  in  1  synchronous active-low reset
iStart  in  1  pulse: leave IDLE, begin dispatching
iOp  in  8  opcode byte from fetch
iOpValid  in  1  iOp valid
oOpReady  out  1  sequencer accepts iOp this cycle
iStall  in  1  datapath cannot consume current uop
iFlagZ  in  1  Z flag from datapath
iIrqReq  in  1  pending interrupt request (level)
iIme  in  1  interrupt master enable
oIrqAck  out  1  one-cycle pulse: interrupt flow entered
oUop  out  UOP_W  current uop
oUopValid  out  1  oUop valid
oUpc  out  ADDR_W  current micro-PC
oPcInc  out  1  one-cycle pulse: advance architectural PC
oBusy  out  1  state != IDLE
iCfgWe  in  1  config write strobe
iCfgSel  in  2  0=ucode RAM, 1=primary table, 2=CB table, 3=ignored
iCfgAddr  in  ADDR_W  write address (tables use [7:0]; ADDR_W >= 8)
iCfgData  in  UOP_W  write data (tables use [ADDR_W-1:0])

Behaviour:
- Storage: ucode RAM 2**ADDR_W x UOP_W; primary and CB tables 256 x ADDR_W each. Asynchronous read, synchronous write. Not cleared by reset. Writes accepted only in IDLE; ignored in all other states.
- States: IDLE, DISPATCH, RUN, CB_WAIT (+ TRAP with option).
- Reset (iReset_n=0 at clock edge): state=IDLE, uPC=0; oUopValid, oOpReady, oIrqAck, oPcInc, oBusy = 0. Applies mid-flow; tables and ucode retained.
- IDLE: iStart -> DISPATCH.
- DISPATCH: if iIrqReq & iIme: oOpReady=0, uPC<=IRQ_FLOW, oIrqAck=1 next cycle, -> RUN; opcode not consumed. Else oOpReady=1; on iOpValid: uPC<=ptab[iOp], -> RUN. First uop valid the cycle after acceptance.
- RUN: oUopValid=1, oUop=ucode[uPC], oUpc=uPC. Uop consumed when oUopValid & !iStall. While iStall, uPC and oUop hold and no pulses are generated.
- Flow codes, acted on at consume:
  - 0 NEXT: uPC+1.
  - 1 INC: uPC+1; oPcInc.
  - 2 EOF: -> DISPATCH.
  - 3 INC_EOF: oPcInc; -> DISPATCH.
  - 4 INC_EOF_Z: oPcInc; if iFlagZ -> DISPATCH, else uPC+1.
  - 5 INC_EOF_NZ: oPcInc; if !iFlagZ -> DISPATCH, else uPC+1.
  - 6 JCB: oPcInc; -> CB_WAIT.
  - 7 reserved: treated as EOF.
- oPcInc is asserted combinationally in the consume cycle.
- uPC+1 wraps modulo 2**ADDR_W (max -> 0); no error.
- CB_WAIT: oUopValid=0, oOpReady=1; on iOpValid uPC<=ctab[iOp], -> RUN. Interrupts are not taken in CB_WAIT.
- Interrupts are sampled only in DISPATCH, never mid-flow. IRQ wins over a simultaneous iOpValid.
- oUopValid=0 in IDLE, DISPATCH, CB_WAIT.
- iStart outside IDLE is ignored.

Optional Feature:
DZCPU_USEQ_ILLEGAL_TRAP_EN
- Defined:
  - A dispatch lookup (primary or CB) returning 0 enters TRAP instead of RUN.
  - In TRAP: oUopValid=0, oOpReady=0. Extra output oIllegal (1 bit) goes high and stays set until reset.
  - Extra output oIllegalOp[7:0] latches the offending opcode; CB-table misses also set oIllegalOp... only via oIllegalCb=1.
- Undefined: entry 0 dispatches normally to flow 0 (generic one-byte op); oIllegal, oIllegalOp and oIllegalCb are absent.

Test Plan:
- Load ucode[5]={NEXT,x}, ucode[6]={INC,x}, ucode[7]={INC_EOF,x}; ptab[0x21]=5; iStart, iOp=0x21 -> oUpc 5,6,7 on three consecutive cycles; oPcInc high on cycles 2,3; then oOpReady=1.
- Same flow with iStall=1 for 3 cycles at uPC=6 -> oUop held 3 cycles, no oPcInc; one oPcInc on release.
- INC_EOF_Z at uPC=19: iFlagZ=1 -> DISPATCH next; iFlagZ=0 -> oUpc=20 next.
- ptab[0xCB]=13 with ucode[13]={JCB}, ctab[0x7C]=16 -> after iOp=0xCB then 0x7C, oUpc=16; iIrqReq=1 during CB_WAIT is ignored.
- In DISPATCH, iIrqReq=1, iIme=1, iOpValid=1 -> oOpReady=0, oIrqAck one pulse, oUpc=238; with iIme=0 -> opcode dispatched normally.
- ucode[255]={NEXT}, ADDR_W=8 -> oUpc wraps 255->0; iReset_n=0 mid-flow -> IDLE, all outputs 0, tables intact after restart; iCfgWe in RUN has no effect.
